// File: rtl/bascomp_pkg.sv
// Shared encodings for the basic-computer control path: control-word bit map,
// bus/ALU selector codes, opcodes and register-reference / I/O bit positions.
package bascomp_pkg;

   localparam int CTRL_AR_LD   = 0;
   localparam int CTRL_AR_INC  = 1;
   localparam int CTRL_AR_CLR  = 2;
   localparam int CTRL_PC_LD   = 3;
   localparam int CTRL_PC_INC  = 4;
   localparam int CTRL_PC_CLR  = 5;
   localparam int CTRL_DR_LD   = 6;
   localparam int CTRL_DR_INC  = 7;
   localparam int CTRL_AC_LD   = 8;
   localparam int CTRL_AC_INC  = 9;
   localparam int CTRL_AC_CLR  = 10;
   localparam int CTRL_IR_LD   = 11;
   localparam int CTRL_TR_LD   = 12;
   localparam int CTRL_OUTR_LD = 13;
   localparam int CTRL_MEM_RD  = 14;
   localparam int CTRL_MEM_WR  = 15;
   localparam int CTRL_E_CLR   = 16;
   localparam int CTRL_E_CMP   = 17;
   localparam int CTRL_FGI_CLR = 18;
   localparam int CTRL_FGO_CLR = 19;

   typedef enum logic [2:0] {
      BUS_NONE = 3'd0,
      BUS_AR   = 3'd1,
      BUS_PC   = 3'd2,
      BUS_DR   = 3'd3,
      BUS_AC   = 3'd4,
      BUS_IR   = 3'd5,
      BUS_TR   = 3'd6,
      BUS_MEM  = 3'd7
   } bus_sel_e;

   typedef enum logic [2:0] {
      ALU_PASS = 3'd0,
      ALU_AND  = 3'd1,
      ALU_ADD  = 3'd2,
      ALU_DR   = 3'd3,
      ALU_CMA  = 3'd4,
      ALU_CIR  = 3'd5,
      ALU_CIL  = 3'd6,
      ALU_INPR = 3'd7
   } alu_op_e;

   localparam logic [2:0] D_AND   = 3'd0;
   localparam logic [2:0] D_ADD   = 3'd1;
   localparam logic [2:0] D_LDA   = 3'd2;
   localparam logic [2:0] D_STA   = 3'd3;
   localparam logic [2:0] D_BUN   = 3'd4;
   localparam logic [2:0] D_BSA   = 3'd5;
   localparam logic [2:0] D_ISZ   = 3'd6;
   localparam logic [2:0] D_REGIO = 3'd7;

   localparam int RR_CLA = 11;
   localparam int RR_CLE = 10;
   localparam int RR_CMA = 9;
   localparam int RR_CME = 8;
   localparam int RR_CIR = 7;
   localparam int RR_CIL = 6;
   localparam int RR_INC = 5;
   localparam int RR_SPA = 4;
   localparam int RR_SNA = 3;
   localparam int RR_SZA = 2;
   localparam int RR_SZE = 1;
   localparam int RR_HLT = 0;

   localparam int IO_INP = 11;
   localparam int IO_OUT = 10;
   localparam int IO_SKI = 9;
   localparam int IO_SKO = 8;
   localparam int IO_ION = 7;
   localparam int IO_IOF = 6;

   // AC update operation for the AND/ADD/LDA group at T5.
   function automatic alu_op_e mem_alu_op(input logic [2:0] d);
      case (d)
         D_AND:   return ALU_AND;
         D_ADD:   return ALU_ADD;
         default: return ALU_DR;
      endcase
   endfunction

endpackage

// File: rtl/timing_decoder.sv
// Sequence-counter value to one-hot timing signal T0..T15.
module timing_decoder (
   input  logic [3:0]  sequence_i,
   output logic [15:0] t_o
);

   always_comb begin
      t_o = 16'd0;
      t_o[sequence_i] = 1'b1;
   end

endmodule

// File: rtl/timing_control_unit.sv
// Instruction-cycle controller: decodes timing state, IR and flags into the
// control word and owns the I, D, R, IEN and S flip-flops.
module timing_control_unit
   import bascomp_pkg::*;
#(
   parameter int ADDR_W = 12,
   parameter int WORD_W = 16,
   parameter int CTRL_W = 20
) (
   input  logic              clk,
   input  logic              rst,
   // counter value; "sequence" itself is a reserved word in SystemVerilog
   input  logic [3:0]        sequence_i,
   input  logic [WORD_W-1:0] ir,
   input  logic              dr_zero,
   input  logic              ac_zero,
   input  logic              ac_sign,
   input  logic              e_flag,
   input  logic              fgi,
   input  logic              fgo,
   input  logic              start,
   output logic              sc_inc,
   output logic              sc_clr,
   output logic [CTRL_W-1:0] ctrl,
   output logic [2:0]        bus_sel,
   output logic [2:0]        alu_op,
   output logic              running,
   output logic              ien
);

   logic [15:0]       t;
   logic [ADDR_W-1:0] op_bits;
   logic              late_t;

   logic              i_q, i_d;
   logic [2:0]        d_q, d_d;
   logic              r_q, r_d;
   logic              ien_q, ien_d;
   logic              s_q, s_d;

   logic [CTRL_W-1:0] ctrl_d;
   bus_sel_e          bus_d;
   alu_op_e           alu_d;
   logic              clr_d;
   logic              used;
   logic              latch_ir;
   logic              hlt;
   logic              ion;
   logic              iof;
   logic              int_done;
   logic              active;

   timing_decoder u_timing_decoder (
      .sequence_i (sequence_i),
      .t_o        (t)
   );

   assign op_bits = ir[ADDR_W-1:0];
   assign late_t  = |t[15:7];

   always_comb begin
      ctrl_d   = '0;
      bus_d    = BUS_NONE;
      alu_d    = ALU_PASS;
      clr_d    = 1'b0;
      used     = 1'b0;
      latch_ir = 1'b0;
      hlt      = 1'b0;
      ion      = 1'b0;
      iof      = 1'b0;
      int_done = 1'b0;

      // T0..T2 belong either to the interrupt cycle or to instruction fetch.
      if (r_q) begin
         if (t[0]) begin
            used = 1'b1;
            ctrl_d[CTRL_AR_CLR] = 1'b1;
            ctrl_d[CTRL_TR_LD]  = 1'b1;
            bus_d = BUS_PC;
         end
         if (t[1]) begin
            used = 1'b1;
            ctrl_d[CTRL_MEM_WR] = 1'b1;
            ctrl_d[CTRL_PC_CLR] = 1'b1;
            bus_d = BUS_TR;
         end
         if (t[2]) begin
            used = 1'b1;
            ctrl_d[CTRL_PC_INC] = 1'b1;
            clr_d    = 1'b1;
            int_done = 1'b1;
         end
      end else begin
         if (t[0]) begin
            used = 1'b1;
            ctrl_d[CTRL_AR_LD] = 1'b1;
            bus_d = BUS_PC;
         end
         if (t[1]) begin
            used = 1'b1;
            ctrl_d[CTRL_MEM_RD] = 1'b1;
            ctrl_d[CTRL_IR_LD]  = 1'b1;
            ctrl_d[CTRL_PC_INC] = 1'b1;
            bus_d = BUS_MEM;
         end
         if (t[2]) begin
            used = 1'b1;
            ctrl_d[CTRL_AR_LD] = 1'b1;
            bus_d    = BUS_IR;
            latch_ir = 1'b1;
         end
      end

      // T3: indirect fetch, or register-reference / I/O execution.
      if (t[3]) begin
         used = 1'b1;
         if (d_q != D_REGIO) begin
            if (i_q) begin
               ctrl_d[CTRL_AR_LD]  = 1'b1;
               ctrl_d[CTRL_MEM_RD] = 1'b1;
               bus_d = BUS_MEM;
            end
         end else if (!i_q) begin
            // descending bit order so the lowest set bit owns alu_op
            if (op_bits[RR_CLA]) ctrl_d[CTRL_AC_CLR] = 1'b1;
            if (op_bits[RR_CLE]) ctrl_d[CTRL_E_CLR]  = 1'b1;
            if (op_bits[RR_CMA]) begin
               ctrl_d[CTRL_AC_LD] = 1'b1;
               alu_d = ALU_CMA;
            end
            if (op_bits[RR_CME]) ctrl_d[CTRL_E_CMP] = 1'b1;
            if (op_bits[RR_CIR]) begin
               ctrl_d[CTRL_AC_LD] = 1'b1;
               alu_d = ALU_CIR;
            end
            if (op_bits[RR_CIL]) begin
               ctrl_d[CTRL_AC_LD] = 1'b1;
               alu_d = ALU_CIL;
            end
            if (op_bits[RR_INC]) ctrl_d[CTRL_AC_INC] = 1'b1;
            if ((op_bits[RR_SPA] && !ac_sign) || (op_bits[RR_SNA] && ac_sign) ||
                (op_bits[RR_SZA] && ac_zero)  || (op_bits[RR_SZE] && !e_flag))
               ctrl_d[CTRL_PC_INC] = 1'b1;
            if (op_bits[RR_HLT]) hlt = 1'b1;
            clr_d = 1'b1;
         end else begin
            if (op_bits[IO_INP]) begin
               ctrl_d[CTRL_AC_LD]   = 1'b1;
               ctrl_d[CTRL_FGI_CLR] = 1'b1;
               alu_d = ALU_INPR;
            end
            if (op_bits[IO_OUT]) begin
               ctrl_d[CTRL_OUTR_LD] = 1'b1;
               ctrl_d[CTRL_FGO_CLR] = 1'b1;
               bus_d = BUS_AC;
            end
            if ((op_bits[IO_SKI] && fgi) || (op_bits[IO_SKO] && fgo))
               ctrl_d[CTRL_PC_INC] = 1'b1;
            if (op_bits[IO_ION]) ion = 1'b1;
            if (op_bits[IO_IOF]) iof = 1'b1;
            clr_d = 1'b1;
         end
      end

      if (d_q != D_REGIO) begin
         case (d_q)
            D_AND, D_ADD, D_LDA: begin
               if (t[4]) begin
                  used = 1'b1;
                  ctrl_d[CTRL_DR_LD]  = 1'b1;
                  ctrl_d[CTRL_MEM_RD] = 1'b1;
                  bus_d = BUS_MEM;
               end
               if (t[5]) begin
                  used = 1'b1;
                  ctrl_d[CTRL_AC_LD] = 1'b1;
                  alu_d = mem_alu_op(d_q);
                  clr_d = 1'b1;
               end
            end
            D_STA: begin
               if (t[4]) begin
                  used = 1'b1;
                  ctrl_d[CTRL_MEM_WR] = 1'b1;
                  bus_d = BUS_AC;
                  clr_d = 1'b1;
               end
            end
            D_BUN: begin
               if (t[4]) begin
                  used = 1'b1;
                  ctrl_d[CTRL_PC_LD] = 1'b1;
                  bus_d = BUS_AR;
                  clr_d = 1'b1;
               end
            end
            D_BSA: begin
               if (t[4]) begin
                  used = 1'b1;
                  ctrl_d[CTRL_MEM_WR] = 1'b1;
                  ctrl_d[CTRL_AR_INC] = 1'b1;
                  bus_d = BUS_PC;
               end
               if (t[5]) begin
                  used = 1'b1;
                  ctrl_d[CTRL_PC_LD] = 1'b1;
                  bus_d = BUS_AR;
                  clr_d = 1'b1;
               end
            end
            D_ISZ: begin
               if (t[4]) begin
                  used = 1'b1;
                  ctrl_d[CTRL_DR_LD]  = 1'b1;
                  ctrl_d[CTRL_MEM_RD] = 1'b1;
                  bus_d = BUS_MEM;
               end
               if (t[5]) begin
                  used = 1'b1;
                  ctrl_d[CTRL_DR_INC] = 1'b1;
               end
               if (t[6]) begin
                  used = 1'b1;
                  ctrl_d[CTRL_MEM_WR] = 1'b1;
                  ctrl_d[CTRL_PC_INC] = dr_zero;
                  bus_d = BUS_DR;
                  clr_d = 1'b1;
               end
            end
            default: ;
         endcase
      end

      // A T-state the current instruction never reaches just restarts the cycle.
      if (!used || late_t) begin
         ctrl_d   = '0;
         bus_d    = BUS_NONE;
         alu_d    = ALU_PASS;
         clr_d    = 1'b1;
         latch_ir = 1'b0;
         hlt      = 1'b0;
         ion      = 1'b0;
         iof      = 1'b0;
         int_done = 1'b0;
      end
   end

   always_comb begin
      i_d   = i_q;
      d_d   = d_q;
      r_d   = r_q;
      ien_d = ien_q;
      s_d   = s_q;
      if (s_q) begin
         if (latch_ir) begin
            i_d = ir[WORD_W-1];
            d_d = ir[WORD_W-2 -: 3];
         end
         if (int_done)
            r_d = 1'b0;
         else if (!(t[0] || t[1] || t[2]) && ien_q && (fgi || fgo))
            r_d = 1'b1;
         if (int_done || iof)
            ien_d = 1'b0;
         else if (ion)
            ien_d = 1'b1;
         if (hlt) s_d = 1'b0;
      end else if (start) begin
         s_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         i_q   <= 1'b0;
         d_q   <= 3'd0;
         r_q   <= 1'b0;
         ien_q <= 1'b0;
         s_q   <= 1'b1;
      end else begin
         i_q   <= i_d;
         d_q   <= d_d;
         r_q   <= r_d;
         ien_q <= ien_d;
         s_q   <= s_d;
      end
   end

   // Reset forces a counter clear; a halted machine drives nothing at all.
   assign active  = !rst && s_q;
   assign sc_clr  = rst || (s_q && clr_d);
   assign sc_inc  = active && !clr_d;
   assign ctrl    = active ? ctrl_d : '0;
   assign bus_sel = active ? bus_d : BUS_NONE;
   assign alu_op  = active ? alu_d : ALU_PASS;
   assign running = s_q;
   assign ien     = ien_q;

endmodule

// File: tb/tb_timing_control_unit.sv
// Directed-vector scoreboard bench for timing_control_unit: the stimulus side
// queues the expected control outputs, a negedge monitor pops and compares.
module tb_timing_control_unit;
   import bascomp_pkg::*;

   localparam logic [19:0] AR_LD   = 20'd1 << CTRL_AR_LD;
   localparam logic [19:0] AR_CLR  = 20'd1 << CTRL_AR_CLR;
   localparam logic [19:0] PC_INC  = 20'd1 << CTRL_PC_INC;
   localparam logic [19:0] PC_CLR  = 20'd1 << CTRL_PC_CLR;
   localparam logic [19:0] DR_LD   = 20'd1 << CTRL_DR_LD;
   localparam logic [19:0] DR_INC  = 20'd1 << CTRL_DR_INC;
   localparam logic [19:0] AC_LD   = 20'd1 << CTRL_AC_LD;
   localparam logic [19:0] AC_CLR  = 20'd1 << CTRL_AC_CLR;
   localparam logic [19:0] IR_LD   = 20'd1 << CTRL_IR_LD;
   localparam logic [19:0] TR_LD   = 20'd1 << CTRL_TR_LD;
   localparam logic [19:0] OUTR_LD = 20'd1 << CTRL_OUTR_LD;
   localparam logic [19:0] MEM_RD  = 20'd1 << CTRL_MEM_RD;
   localparam logic [19:0] MEM_WR  = 20'd1 << CTRL_MEM_WR;
   localparam logic [19:0] FGO_CLR = 20'd1 << CTRL_FGO_CLR;

   localparam logic [2:0] B0 = 3'd0, B_AR = 3'd1, B_PC = 3'd2, B_DR = 3'd3;
   localparam logic [2:0] B_AC = 3'd4, B_IR = 3'd5, B_TR = 3'd6, B_MEM = 3'd7;
   localparam logic [2:0] A0 = 3'd0, A_ADD = 3'd2, A_CIL = 3'd6;

   // flag bundle order: {start, fgo, fgi, e_flag, ac_sign, ac_zero, dr_zero}
   localparam logic [6:0] F_NONE  = 7'b0000000;
   localparam logic [6:0] F_DRZ   = 7'b0000001;
   localparam logic [6:0] F_ACZ   = 7'b0000010;
   localparam logic [6:0] F_FGI   = 7'b0010000;
   localparam logic [6:0] F_START = 7'b1000000;

   typedef struct packed {
      logic        inc;
      logic        clr;
      logic [19:0] ctrl;
      logic [2:0]  bus;
      logic [2:0]  alu;
      logic        run;
      logic        ien;
   } obs_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  seq = 4'd0;
   logic [15:0] ir = 16'd0;
   logic        dr_zero = 1'b0, ac_zero = 1'b0, ac_sign = 1'b0, e_flag = 1'b0;
   logic        fgi = 1'b0, fgo = 1'b0, start = 1'b0;
   logic        sc_inc, sc_clr, running, ien;
   logic [19:0] ctrl;
   logic [2:0]  bus_sel, alu_op;

   obs_t  exp_q[$];
   string name_q[$];
   obs_t  exp_cur, act;
   string name_cur;
   int    n_tests = 0;
   int    n_fail  = 0;

   timing_control_unit #(.ADDR_W(12), .WORD_W(16), .CTRL_W(20)) dut (
      .clk        (clk),
      .rst        (rst),
      .sequence_i (seq),
      .ir         (ir),
      .dr_zero    (dr_zero),
      .ac_zero    (ac_zero),
      .ac_sign    (ac_sign),
      .e_flag     (e_flag),
      .fgi        (fgi),
      .fgo        (fgo),
      .start      (start),
      .sc_inc     (sc_inc),
      .sc_clr     (sc_clr),
      .ctrl       (ctrl),
      .bus_sel    (bus_sel),
      .alu_op     (alu_op),
      .running    (running),
      .ien        (ien)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_cur  = exp_q.pop_front();
         name_cur = name_q.pop_front();
         act = {sc_inc, sc_clr, ctrl, bus_sel, alu_op, running, ien};
         n_tests++;
         if (act !== exp_cur) begin
            n_fail++;
            $display("FAIL %s: got inc=%b clr=%b ctrl=%h bus=%0d alu=%0d run=%b ien=%b; required inc=%b clr=%b ctrl=%h bus=%0d alu=%0d run=%b ien=%b",
                     name_cur, act.inc, act.clr, act.ctrl, act.bus, act.alu, act.run, act.ien,
                     exp_cur.inc, exp_cur.clr, exp_cur.ctrl, exp_cur.bus, exp_cur.alu,
                     exp_cur.run, exp_cur.ien);
         end
      end
   end

   task automatic step(input string nm, input logic r, input logic [3:0] s,
                       input logic [15:0] irv, input logic [6:0] fl,
                       input logic [19:0] c, input logic [2:0] b, input logic [2:0] a,
                       input logic inc, input logic clr, input logic run, input logic ie);
      obs_t e;
      @(posedge clk);
      #1;
      rst = r;
      seq = s;
      ir  = irv;
      {start, fgo, fgi, e_flag, ac_sign, ac_zero, dr_zero} = fl;
      e = {inc, clr, c, b, a, run, ie};
      exp_q.push_back(e);
      name_q.push_back(nm);
   endtask

   task automatic fetch(input logic [15:0] irv, input logic ie);
      step("fetch_T0", 1'b0, 4'd0, irv, F_NONE, AR_LD, B_PC, A0, 1'b1, 1'b0, 1'b1, ie);
      step("fetch_T1", 1'b0, 4'd1, irv, F_NONE, MEM_RD | IR_LD | PC_INC, B_MEM, A0,
           1'b1, 1'b0, 1'b1, ie);
      step("fetch_T2", 1'b0, 4'd2, irv, F_NONE, AR_LD, B_IR, A0, 1'b1, 1'b0, 1'b1, ie);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, required normal completion");
      $fatal(1, "watchdog");
   end

   initial begin
      // reset holds the counter clear
      step("reset_a", 1'b1, 4'd5, 16'h7800, F_NONE, '0, B0, A0, 1'b0, 1'b1, 1'b1, 1'b0);
      step("reset_b", 1'b1, 4'd3, 16'h7800, F_NONE, '0, B0, A0, 1'b0, 1'b1, 1'b1, 1'b0);

      // CLA, then an out-of-range T-state
      fetch(16'h7800, 1'b0);
      step("cla_T3", 1'b0, 4'd3, 16'h7800, F_NONE, AC_CLR, B0, A0, 1'b0, 1'b1, 1'b1, 1'b0);
      step("illegal_T9", 1'b0, 4'd9, 16'h7800, F_NONE, '0, B0, A0, 1'b0, 1'b1, 1'b1, 1'b0);

      // ADD direct, then T6 which ADD never uses
      fetch(16'h1123, 1'b0);
      step("add_T3", 1'b0, 4'd3, 16'h1123, F_NONE, '0, B0, A0, 1'b1, 1'b0, 1'b1, 1'b0);
      step("add_T4", 1'b0, 4'd4, 16'h1123, F_NONE, DR_LD | MEM_RD, B_MEM, A0,
           1'b1, 1'b0, 1'b1, 1'b0);
      step("add_T5", 1'b0, 4'd5, 16'h1123, F_NONE, AC_LD, B0, A_ADD, 1'b0, 1'b1, 1'b1, 1'b0);
      step("add_T6_illegal", 1'b0, 4'd6, 16'h1123, F_NONE, '0, B0, A0, 1'b0, 1'b1, 1'b1, 1'b0);

      // ADD indirect
      fetch(16'h9123, 1'b0);
      step("addi_T3", 1'b0, 4'd3, 16'h9123, F_NONE, AR_LD | MEM_RD, B_MEM, A0,
           1'b1, 1'b0, 1'b1, 1'b0);
      step("addi_T4", 1'b0, 4'd4, 16'h9123, F_NONE, DR_LD | MEM_RD, B_MEM, A0,
           1'b1, 1'b0, 1'b1, 1'b0);
      step("addi_T5", 1'b0, 4'd5, 16'h9123, F_NONE, AC_LD, B0, A_ADD, 1'b0, 1'b1, 1'b1, 1'b0);

      // ISZ with DR==0 then DR!=0 at T6
      fetch(16'h6050, 1'b0);
      step("isz_T3", 1'b0, 4'd3, 16'h6050, F_NONE, '0, B0, A0, 1'b1, 1'b0, 1'b1, 1'b0);
      step("isz_T4", 1'b0, 4'd4, 16'h6050, F_NONE, DR_LD | MEM_RD, B_MEM, A0,
           1'b1, 1'b0, 1'b1, 1'b0);
      step("isz_T5", 1'b0, 4'd5, 16'h6050, F_NONE, DR_INC, B0, A0, 1'b1, 1'b0, 1'b1, 1'b0);
      step("isz_T6_zero", 1'b0, 4'd6, 16'h6050, F_DRZ, MEM_WR | PC_INC, B_DR, A0,
           1'b0, 1'b1, 1'b1, 1'b0);
      step("isz_T6_nz", 1'b0, 4'd6, 16'h6050, F_NONE, MEM_WR, B_DR, A0,
           1'b0, 1'b1, 1'b1, 1'b0);

      // CMA+CIL+SZA: actions OR-ed, CIL (lower bit) owns alu_op, skip taken
      fetch(16'h7244, 1'b0);
      step("rr_multi_T3", 1'b0, 4'd3, 16'h7244, F_ACZ, AC_LD | PC_INC, B0, A_CIL,
           1'b0, 1'b1, 1'b1, 1'b0);

      // OUT+SKI with FGI set while IEN is off
      fetch(16'hF600, 1'b0);
      step("io_out_ski_T3", 1'b0, 4'd3, 16'hF600, F_FGI, OUTR_LD | FGO_CLR | PC_INC, B_AC, A0,
           1'b0, 1'b1, 1'b1, 1'b0);

      // ION, then an interrupt raised during the next instruction's T4
      fetch(16'hF080, 1'b0);
      step("ion_T3", 1'b0, 4'd3, 16'hF080, F_NONE, '0, B0, A0, 1'b0, 1'b1, 1'b1, 1'b0);
      fetch(16'h1123, 1'b1);
      step("int_add_T3", 1'b0, 4'd3, 16'h1123, F_NONE, '0, B0, A0, 1'b1, 1'b0, 1'b1, 1'b1);
      step("int_add_T4", 1'b0, 4'd4, 16'h1123, F_FGI, DR_LD | MEM_RD, B_MEM, A0,
           1'b1, 1'b0, 1'b1, 1'b1);
      step("int_add_T5", 1'b0, 4'd5, 16'h1123, F_NONE, AC_LD, B0, A_ADD, 1'b0, 1'b1, 1'b1, 1'b1);
      step("intcyc_T0", 1'b0, 4'd0, 16'h1123, F_NONE, AR_CLR | TR_LD, B_PC, A0,
           1'b1, 1'b0, 1'b1, 1'b1);
      step("intcyc_T1", 1'b0, 4'd1, 16'h1123, F_NONE, MEM_WR | PC_CLR, B_TR, A0,
           1'b1, 1'b0, 1'b1, 1'b1);
      step("intcyc_T2", 1'b0, 4'd2, 16'h1123, F_NONE, PC_INC, B0, A0, 1'b0, 1'b1, 1'b1, 1'b1);

      // HLT with a coincident start pulse: halt wins, then resume on start
      fetch(16'h7001, 1'b0);
      step("hlt_T3", 1'b0, 4'd3, 16'h7001, F_START, '0, B0, A0, 1'b0, 1'b1, 1'b1, 1'b0);
      for (int k = 0; k < 10; k++)
         step("halted", 1'b0, 4'd0, 16'h7001, F_NONE, '0, B0, A0, 1'b0, 1'b0, 1'b0, 1'b0);
      step("start_pulse", 1'b0, 4'd0, 16'h7001, F_START, '0, B0, A0,
           1'b0, 1'b0, 1'b0, 1'b0);
      step("resume_T0", 1'b0, 4'd0, 16'h7800, F_NONE, AR_LD, B_PC, A0, 1'b1, 1'b0, 1'b1, 1'b0);
      step("resume_T1", 1'b0, 4'd1, 16'h7800, F_NONE, MEM_RD | IR_LD | PC_INC, B_MEM, A0,
           1'b1, 1'b0, 1'b1, 1'b0);

      for (int k = 0; k < 5 && exp_q.size() > 0; k++)
         @(negedge clk);
      #1;
      if (exp_q.size() > 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/timing_control_unit.md
Name: timing_control_unit

Overview:
- Control-sequencing stage for the basic computer; sits directly downstream of the 4-bit sequence counter.
- Consumes the counter's `sequence` value (T0..T15) plus IR and status flags, and produces the register/bus/ALU/memory control word.
- Drives the counter's `inc`/`clr` back, closing the instruction-cycle loop: fetch, decode, indirect, execute, interrupt.
- Owns the I, R (interrupt cycle), IEN and S (run) flip-flops.

Parameters:
- ADDR_W, 12, address width (AR, PC, IR[11:0]).
- WORD_W, 16, data word width.
- CTRL_W, 20, width of control word `ctrl`.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- rst  in  1  synchronous, active-high reset.
- sequence  in  4  current timing state from sequence counter.
- ir  in  WORD_W  instruction register contents.
- dr_zero  in  1  DR == 0.
- ac_zero  in  1  AC == 0.
- ac_sign  in  1  AC[15].
- e_flag  in  1  E flip-flop.
- fgi  in  1  input flag.
- fgo  in  1  output flag.
- start  in  1  sets S (resume after HLT).
- sc_inc  out  1  increment sequence counter.
- sc_clr  out  1  clear sequence counter.
- ctrl  out  CTRL_W  one-hot-per-action control word (bit map in package).
- bus_sel  out  3  common-bus source: 0 none, 1 AR, 2 PC, 3 DR, 4 AC, 5 IR, 6 TR, 7 MEM.
- alu_op  out  3  0 pass, 1 AND, 2 ADD, 3 DR, 4 CMA, 5 CIR, 6 CIL, 7 INPR.
- running  out  1  S flip-flop.
- ien  out  1  IEN flip-flop.

Behaviour:
- Registered state:
  - I: latched from ir[15] when R=0 and T2.
  - opcode D[2:0]: latched from ir[14:12] at the same point.
  - R, IEN, S.
- Reset (rst high at posedge): I=0, D=0, R=0, IEN=0, S=1. While rst is high the outputs are forced to sc_clr=1, sc_inc=0, ctrl=0, bus_sel=0, alu_op=0, so counter and controller restart together at T0.
- Outputs are a combinational decode of (state, sequence, ir, flags). They are valid in the same cycle and take effect at the next posedge. Control latency is therefore 0 cycles; state updates 1 cycle.
- sc_inc = S & ~sc_clr. When S=0, every output is 0, including sc_inc and sc_clr.
- Fetch (R=0):
  - T0: AR<-PC.
  - T1: IR<-M[AR], PC++.
  - T2: AR<-IR[11:0]; latch I and D.
- Indirect: D!=7 & I & T3: AR<-M[AR]. D!=7 & ~I & T3: no operation.
- Memory-reference execute:
  - AND/ADD/LDA: T4 DR<-M; T5 AC op DR, ADD updates E via ALU; clr.
  - STA: T4 M<-AC; clr.
  - BUN: T4 PC<-AR; clr.
  - BSA: T4 M<-PC, AR++; T5 PC<-AR; clr.
  - ISZ: T4 DR<-M; T5 DR++; T6 M<-DR, PC++ if dr_zero; clr.
- Register-reference (D=7, I=0, T3), by ir[11:0] bit:
  - CLA, CLE, CMA, CME, CIR, CIL, INC.
  - SPA (~ac_sign), SNA (ac_sign), SZA (ac_zero), SZE (~e_flag): each skips via pc_inc.
  - HLT: S<-0.
  - Then clr.
- I/O (D=7, I=1, T3):
  - INP: AC[7:0]<-INPR, fgi_clr.
  - OUT: OUTR<-AC[7:0], fgo_clr.
  - SKI (fgi), SKO (fgo): skip via pc_inc.
  - ION: IEN<-1. IOF: IEN<-0.
  - Then clr.
- Multiple bits set in one register/I/O instruction:
  - All corresponding actions are OR-ed.
  - bus_sel/alu_op priority is lowest bit index.
- Interrupt detect: at a posedge with S=1, sequence not in {0,1,2}, IEN=1 and (fgi|fgo), set R<-1.
- Interrupt cycle (R=1):
  - T0: AR<-0, TR<-PC.
  - T1: M<-TR, PC<-0.
  - T2: PC++, IEN<-0, R<-0; clr.
- Illegal sequence (S=1 and a T-state the current instruction does not use, e.g. T7..T15): assert sc_clr only, with no other control.
- Simultaneous events:
  - HLT with start: HLT wins.
  - start while S=1: no effect.
  - Interrupt detect coinciding with HLT: R is still set; it is serviced after start.

Decomposition:
- Package `bascomp_pkg` holds:
  - CTRL bit indices: ar_ld, ar_inc, ar_clr, pc_ld, pc_inc, pc_clr, dr_ld, dr_inc, ac_ld, ac_inc, ac_clr, ir_ld, tr_ld, outr_ld, mem_rd, mem_wr, e_clr, e_cmp, fgi_clr, fgo_clr.
  - BUS_* and ALU_* codes.
  - Opcode constants D_AND..D_REGIO.
  - Register/I/O bit positions.
- One natural sub-module, `timing_decoder`: sequence[3:0] -> t[15:0] one-hot, purely combinational.

Test Plan:
- Reset, then 3 cycles with ir=16'h7800 (CLA, during fetch from memory) -> sc_clr=1 during rst; T0 bus_sel=2, ar_ld; T1 mem_rd, ir_ld, pc_inc; T3 ac_clr, sc_clr.
- ir=16'h1123 (ADD direct) -> T4 dr_ld, bus_sel=7; T5 ac_ld, alu_op=2, sc_clr; sc_inc high in T0..T4.
- ir=16'h9123 (ADD indirect) -> T3 ar_ld, bus_sel=7; same T4/T5 as above.
- ir=16'h6050 (ISZ) with dr_zero=1 at T6 -> T6 mem_wr, bus_sel=3, pc_inc, sc_clr; with dr_zero=0, pc_inc=0.
- ION (16'hF080), then fgi=1 during next instruction's T4 -> R=1; next T0 ar_clr, tr_ld; T1 mem_wr, bus_sel=6, pc_clr; T2 pc_inc, sc_clr; ien=0 afterward.
- HLT (16'h7001) -> running=0 after T3 and all outputs 0 for 10 cycles; start pulse -> running=1, fetch resumes.
